ext_arbiter: RTL and testbench
==============================

// Module: ext_arbiter
// PURPOSE
//   Shares the single immediate extender between two requesters: decode
//   stage (port 0) and branch/jump target unit (port 1). Drives the
//   extender's ext_op/imm16/imm9 inputs for the granted requester and
//   captures the returned 32-bit ext_imm into a one-entry response buffer.
//   Each side uses a valid/ready handshake. Sits in ID beside the extender.
// PARAMETERS
//   TAG_W    4   width of the requester tag carried through to the response
//   STALL_W  8   width of the saturating response-stall counter
// PORTS
//   clk          in   1       clock, all state on rising edge
//   rst_n        in   1       asynchronous reset, active-low
//   r0_valid     in   1       port 0 request valid
//   r0_ready     out  1       port 0 request accepted this cycle
//   r0_op        in   2       port 0 ext_op (0 zero16, 1 lui, 2 sign16, 3 sign9)
//   r0_imm16     in   16      port 0 16-bit immediate
//   r0_imm9      in   9       port 0 9-bit immediate
//   r0_tag       in   TAG_W   port 0 tag
//   r1_*         -    -       same set for port 1
//   ext_op       out  2       to extender
//   imm16        out  16      to extender
//   imm9         out  9       to extender
//   ext_imm      in   32      from extender (combinational, same cycle)
//   rsp_valid    out  1       response buffer holds a result
//   rsp_ready    in   1       consumer takes response
//   rsp_imm      out  32      extended immediate
//   rsp_id       out  1       which port issued it (0/1)
//   rsp_tag      out  TAG_W   tag of the issuing request
//   stall_cnt    out  STALL_W cycles with rsp_valid=1 and rsp_ready=0
// BEHAVIOUR
//   - Reset (async, rst_n=0): rsp_valid=0, rsp_imm=0, rsp_id=0, rsp_tag=0,
//     stall_cnt=0, last_grant=1 (port 0 favoured first). Mid-transfer reset
//     drops the buffered response; no request is accepted during reset.
//   - Buffer FSM: EMPTY (rsp_valid=0) / FULL (rsp_valid=1).
//     can_accept = EMPTY | rsp_ready.
//     EMPTY + accept -> FULL; FULL + rsp_ready + no accept -> EMPTY;
//     FULL + rsp_ready + accept -> FULL (new data, back-to-back, no bubble);
//     FULL + !rsp_ready -> FULL, all rsp_* held stable.
//   - Grant (combinational): only one valid -> that port; both valid ->
//     port != last_grant (round-robin, see CONFIGURATION); none -> no grant.
//   - rN_ready = grant_N & can_accept. Accept = valid & ready on either port.
//   - Extender drive: granted port's op/imm16/imm9; no grant -> all zero.
//   - On accept: rsp_imm<=ext_imm, rsp_id<=granted port, rsp_tag<=its tag,
//     rsp_valid<=1; last_grant<=granted port. last_grant never changes
//     without an accept, so a blocked grant stays on the same port.
//   - Latency: request accepted cycle N -> rsp_valid cycle N+1. Throughput
//     one per cycle while rsp_ready=1.
//   - Requesters hold valid and payload until ready; arbiter never retracts
//     a grant while can_accept=0 and inputs are stable.
//   - stall_cnt +1 each cycle rsp_valid & !rsp_ready; saturates at all-ones;
//     never wraps; cleared only by reset.
//   - ext_op is 2 bits: all four codes legal, no default case needed.
// CONFIGURATION
//   EXT_ARB_RR_EN defined: round-robin as above; worst-case wait for a
//     continuously valid port is one accept of the other port.
//   EXT_ARB_RR_EN undefined: fixed priority, port 0 always wins when both
//     valid; last_grant still updated but ignored; port 1 may starve.
// TESTING
//   - Reset: rst_n=0 mid-FULL with rsp_ready=0 -> rsp_valid=0, stall_cnt=0
//     at once; after release first dual request grants port 0.
//   - Single: r0 op=2 imm16=16'h8001 -> next cycle rsp_imm=32'hFFFF8001,
//     rsp_id=0; r1 op=3 imm9=9'h100 -> rsp_imm=32'hFFFFFF00, rsp_id=1.
//   - Contention (RR_EN): both valid 4 cycles, rsp_ready=1 -> rsp_id 0,1,0,1,
//     one response per cycle; without macro -> 0,0,0,0, r1_ready never 1.
//   - Backpressure: FULL, rsp_ready=0 for 3 cycles, r0 valid -> r0_ready=0,
//     rsp_* stable, stall_cnt=3; rsp_ready=1 -> r0 accepted same cycle.
//   - Saturation: STALL_W=8, hold rsp_ready=0 300 cycles -> stall_cnt=8'hFF.
//   - Idle drive: no valid -> ext_op=0, imm16=0, imm9=0, last_grant unchanged.

Source files
------------

// File: rtl/ext_arbiter_if.sv
// ---------------------------------------------------------------------------
// ext_arbiter_if
// Bundles every handshake and data signal around ext_arbiter: the two
// requester ports, the drive/return path of the shared immediate extender,
// and the response buffer outputs.
//
// Parameters:
//   TAG_W    width of the requester tag
//   STALL_W  width of the saturating response-stall counter
//
// Signal groups:
//   r0_* / r1_*          requester valid/ready plus op, imm16, imm9, tag
//   ext_op/imm16/imm9    arbiter -> extender
//   ext_imm              extender -> arbiter (combinational, same cycle)
//   rsp_*                one-entry response buffer with valid/ready
//   stall_cnt            cycles the response sat unconsumed (saturating)
//
// Modports:
//   slave   the arbiter's view (takes requests, serves responses)
//   master  the surrounding logic's view (requesters, extender, consumer)
// ---------------------------------------------------------------------------
interface ext_arbiter_if #(
    parameter int TAG_W   = 4,
    parameter int STALL_W = 8
);
    logic               r0_valid;
    logic               r0_ready;
    logic [1:0]         r0_op;
    logic [15:0]        r0_imm16;
    logic [8:0]         r0_imm9;
    logic [TAG_W-1:0]   r0_tag;

    logic               r1_valid;
    logic               r1_ready;
    logic [1:0]         r1_op;
    logic [15:0]        r1_imm16;
    logic [8:0]         r1_imm9;
    logic [TAG_W-1:0]   r1_tag;

    logic [1:0]         ext_op;
    logic [15:0]        imm16;
    logic [8:0]         imm9;
    logic [31:0]        ext_imm;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_imm;
    logic               rsp_id;
    logic [TAG_W-1:0]   rsp_tag;
    logic [STALL_W-1:0] stall_cnt;

    modport slave (
        input  r0_valid, r0_op, r0_imm16, r0_imm9, r0_tag,
        input  r1_valid, r1_op, r1_imm16, r1_imm9, r1_tag,
        output r0_ready, r1_ready,
        output ext_op, imm16, imm9,
        input  ext_imm,
        output rsp_valid, rsp_imm, rsp_id, rsp_tag, stall_cnt,
        input  rsp_ready
    );

    modport master (
        output r0_valid, r0_op, r0_imm16, r0_imm9, r0_tag,
        output r1_valid, r1_op, r1_imm16, r1_imm9, r1_tag,
        input  r0_ready, r1_ready,
        input  ext_op, imm16, imm9,
        output ext_imm,
        input  rsp_valid, rsp_imm, rsp_id, rsp_tag, stall_cnt,
        output rsp_ready
    );
endinterface

// File: rtl/ext_arbiter.sv
// ---------------------------------------------------------------------------
// ext_arbiter
// Shares the single immediate extender between the decode stage (port 0)
// and the branch/jump target unit (port 1). The granted requester's
// op/imm16/imm9 are driven to the extender and the returned ext_imm is
// captured into a one-entry response buffer together with the port id and
// the requester's tag. Request accepted in cycle N -> rsp_valid in N+1;
// one response per cycle while rsp_ready stays high.
//
// Ports:
//   clk    clock, all state on the rising edge
//   rst_n  asynchronous reset, active-low
//   bus    ext_arbiter_if.slave (requesters, extender, response, stall_cnt)
//
// Configuration macro:
//   EXT_ARB_RR_EN  defined   -> round-robin between simultaneous requests
//                  undefined -> fixed priority, port 0 always wins
// ---------------------------------------------------------------------------
module ext_arbiter #(
    parameter int TAG_W   = 4,
    parameter int STALL_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    ext_arbiter_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t         state_q;
    buf_state_t         state_d;

    logic               last_grant_q;
    logic               has_grant;
    logic               grant_port;
    logic               can_accept;
    logic               accept;

    logic [31:0]        rsp_imm_q;
    logic               rsp_id_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic [STALL_W-1:0] stall_q;

    // Grant selection. With both ports valid the round-robin build picks
    // the port that did not win last time; the fixed-priority build always
    // picks port 0. last_grant is still maintained in the fixed build but
    // is masked off so it cannot influence the choice.
    always_comb begin
        has_grant  = bus.r0_valid | bus.r1_valid;
        grant_port = 1'b0;
        if (bus.r0_valid && bus.r1_valid) begin
`ifdef EXT_ARB_RR_EN
            grant_port = ~last_grant_q;
`else
            grant_port = last_grant_q & 1'b0;
`endif
        end else if (bus.r1_valid) begin
            grant_port = 1'b1;
        end
    end

    // The buffer can take a new result when it is empty or when its
    // current content leaves this very cycle, which gives back-to-back
    // transfers with no bubble.
    always_comb begin
        can_accept = (state_q == EMPTY) | bus.rsp_ready;
        accept     = has_grant & can_accept;
    end

    // Buffer FSM next state plus the combinational handshake and
    // extender drive. Without a grant the extender inputs are parked at
    // zero so it does not toggle on idle cycles.
    always_comb begin
        state_d      = state_q;
        bus.r0_ready = has_grant & ~grant_port & can_accept;
        bus.r1_ready = has_grant &  grant_port & can_accept;
        bus.ext_op   = 2'd0;
        bus.imm16    = 16'd0;
        bus.imm9     = 9'd0;

        if (has_grant) begin
            if (grant_port) begin
                bus.ext_op = bus.r1_op;
                bus.imm16  = bus.r1_imm16;
                bus.imm9   = bus.r1_imm9;
            end else begin
                bus.ext_op = bus.r0_op;
                bus.imm16  = bus.r0_imm16;
                bus.imm9   = bus.r0_imm9;
            end
        end

        case (state_q)
            EMPTY: if (accept)                   state_d = FULL;
            FULL:  if (bus.rsp_ready && !accept) state_d = EMPTY;
        endcase
    end

    // Buffer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Response payload and grant history only move on an accept, so a
    // blocked grant stays on the same port and held responses stay stable.
    // last_grant resets to 1 so port 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_imm_q    <= 32'd0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            rsp_imm_q    <= bus.ext_imm;
            rsp_id_q     <= grant_port;
            rsp_tag_q    <= grant_port ? bus.r1_tag : bus.r0_tag;
            last_grant_q <= grant_port;
        end
    end

    // Counts cycles a response waits on the consumer; sticks at all-ones
    // and is only cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((state_q == FULL) && !bus.rsp_ready && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_imm   = rsp_imm_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_ext_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ext_arbiter
// Directed bench for ext_arbiter. A transaction-level model of the
// arbiter (grant rule, one-entry buffer, saturating stall counter) runs
// alongside the DUT and is compared with it every cycle; literal
// expectations from worked examples pin the model. The extender is
// modelled here and drives ext_imm from the DUT's extender outputs.
// ---------------------------------------------------------------------------
module tb_ext_arbiter;

    localparam int TAG_W     = 4;
    localparam int STALL_W   = 8;
    localparam int STALL_MAX = (1 << STALL_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ext_arbiter_if #(.TAG_W(TAG_W), .STALL_W(STALL_W)) bus ();

    ext_arbiter #(.TAG_W(TAG_W), .STALL_W(STALL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Extender: 0 zero16, 1 lui, 2 sign16, 3 sign9.
    function automatic logic [31:0] extend(input logic [1:0] op,
                                           input logic [15:0] i16,
                                           input logic [8:0] i9);
        case (op)
            2'd0:    return {16'h0000, i16};
            2'd1:    return {i16, 16'h0000};
            2'd2:    return {{16{i16[15]}}, i16};
            default: return {{23{i9[8]}}, i9};
        endcase
    endfunction

    assign bus.ext_imm = extend(bus.ext_op, bus.imm16, bus.imm9);

    // Model state.
    bit               m_valid = 1'b0;
    logic [31:0]      m_imm   = 32'd0;
    bit               m_id    = 1'b0;
    logic [TAG_W-1:0] m_tag   = '0;
    int               m_stall = 0;
`ifdef EXT_ARB_RR_EN
    bit               m_last  = 1'b1;
`endif

    // Which port wins given the current valids; -1 when nobody asks.
    function automatic int pick(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef EXT_ARB_RR_EN
            return m_last ? 0 : 1;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every clock edge or asynchronous reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_imm   = 32'd0;
            m_id    = 1'b0;
            m_tag   = '0;
            m_stall = 0;
`ifdef EXT_ARB_RR_EN
            m_last  = 1'b1;
`endif
        end else begin
            int g;
            bit acc;
            g   = pick(bus.r0_valid, bus.r1_valid);
            acc = (g >= 0) && (!m_valid || bus.rsp_ready);
            if (m_valid && !bus.rsp_ready && m_stall < STALL_MAX) m_stall++;
            if (acc) begin
                m_valid = 1'b1;
                m_id    = (g == 1);
                if (g == 1) begin
                    m_imm = extend(bus.r1_op, bus.r1_imm16, bus.r1_imm9);
                    m_tag = bus.r1_tag;
                end else begin
                    m_imm = extend(bus.r0_op, bus.r0_imm16, bus.r0_imm9);
                    m_tag = bus.r0_tag;
                end
`ifdef EXT_ARB_RR_EN
                m_last = (g == 1);
`endif
            end else if (bus.rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                int g;
                bit can;
                logic [1:0]  e_op;
                logic [15:0] e_i16;
                logic [8:0]  e_i9;
                g     = pick(bus.r0_valid, bus.r1_valid);
                can   = !m_valid || bus.rsp_ready;
                e_op  = (g == 0) ? bus.r0_op    : (g == 1) ? bus.r1_op    : 2'd0;
                e_i16 = (g == 0) ? bus.r0_imm16 : (g == 1) ? bus.r1_imm16 : 16'd0;
                e_i9  = (g == 0) ? bus.r0_imm9  : (g == 1) ? bus.r1_imm9  : 9'd0;
                checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
                checkOutput("rsp_imm",   bus.rsp_imm,         m_imm);
                checkOutput("rsp_id",    32'(bus.rsp_id),     32'(m_id));
                checkOutput("rsp_tag",   32'(bus.rsp_tag),    32'(m_tag));
                checkOutput("stall_cnt", 32'(bus.stall_cnt),  32'(m_stall));
                checkOutput("r0_ready",  32'(bus.r0_ready),   32'((g == 0) && can));
                checkOutput("r1_ready",  32'(bus.r1_ready),   32'((g == 1) && can));
                checkOutput("ext_op",    32'(bus.ext_op),     32'(e_op));
                checkOutput("imm16",     32'(bus.imm16),      32'(e_i16));
                checkOutput("imm9",      32'(bus.imm9),       32'(e_i9));
            end
        end
    end

    task automatic driveInputs(
        input logic v0, input logic [1:0] op0, input logic [15:0] a0,
        input logic [8:0] b0, input logic [TAG_W-1:0] t0,
        input logic v1, input logic [1:0] op1, input logic [15:0] a1,
        input logic [8:0] b1, input logic [TAG_W-1:0] t1);
        bus.r0_valid = v0; bus.r0_op = op0; bus.r0_imm16 = a0;
        bus.r0_imm9  = b0; bus.r0_tag = t0;
        bus.r1_valid = v1; bus.r1_op = op1; bus.r1_imm16 = a1;
        bus.r1_imm9  = b1; bus.r1_tag = t1;
    endtask

    // Hold the given inputs for one full clock cycle.
    task automatic applyStimulus(
        input logic v0, input logic [1:0] op0, input logic [15:0] a0,
        input logic [8:0] b0, input logic [TAG_W-1:0] t0,
        input logic v1, input logic [1:0] op1, input logic [15:0] a1,
        input logic [8:0] b1, input logic [TAG_W-1:0] t1);
        driveInputs(v0, op0, a0, b0, t0, v1, op1, a1, b1, t1);
        @(negedge clk);
    endtask

    initial begin
        driveInputs(0, 2'd0, 16'h0, 9'h0, 4'h0, 0, 2'd0, 16'h0, 9'h0, 4'h0);
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values.
        checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset rsp_imm",   bus.rsp_imm,         32'd0);
        checkOutput("reset rsp_tag",   32'(bus.rsp_tag),    32'd0);
        checkOutput("reset stall_cnt", 32'(bus.stall_cnt),  32'd0);
        rst_n = 1'b1;

        // Single request on each port.
        applyStimulus(1, 2'd2, 16'h8001, 9'h000, 4'hA, 0, 2'd0, 16'h0, 9'h0, 4'h0);
        checkOutput("single0 rsp_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("single0 rsp_imm",   bus.rsp_imm,         32'hFFFF8001);
        checkOutput("single0 rsp_id",    32'(bus.rsp_id),     32'd0);
        checkOutput("single0 rsp_tag",   32'(bus.rsp_tag),    32'hA);
        applyStimulus(0, 2'd0, 16'h0, 9'h0, 4'h0, 1, 2'd3, 16'h0000, 9'h100, 4'hB);
        checkOutput("single1 rsp_imm",   bus.rsp_imm,         32'hFFFFFF00);
        checkOutput("single1 rsp_id",    32'(bus.rsp_id),     32'd1);
        checkOutput("single1 rsp_tag",   32'(bus.rsp_tag),    32'hB);

        // Contention: both valid for four cycles, consumer always ready.
        for (int i = 0; i < 4; i++) begin
            driveInputs(1, 2'd0, 16'h1230 + 16'(i), 9'h0, 4'h3,
                        1, 2'd1, 16'h4560 + 16'(i), 9'h0, 4'h7);
            #1;
`ifdef EXT_ARB_RR_EN
            checkOutput("contend r1_ready", 32'(bus.r1_ready), 32'(i % 2));
`else
            checkOutput("contend r1_ready", 32'(bus.r1_ready), 32'd0);
`endif
            @(negedge clk);
            checkOutput("contend rsp_valid", 32'(bus.rsp_valid), 32'd1);
`ifdef EXT_ARB_RR_EN
            checkOutput("contend rsp_id", 32'(bus.rsp_id), 32'(i % 2));
`else
            checkOutput("contend rsp_id", 32'(bus.rsp_id), 32'd0);
            checkOutput("contend rsp_imm", bus.rsp_imm, 32'h0000_1230 + 32'(i));
`endif
        end

        // Idle: payload present but nothing valid -> extender parked at zero.
        driveInputs(0, 2'd3, 16'hFFFF, 9'h1FF, 4'hF, 0, 2'd2, 16'hBEEF, 9'h0AA, 4'hE);
        #1;
        checkOutput("idle ext_op", 32'(bus.ext_op), 32'd0);
        checkOutput("idle imm16",  32'(bus.imm16),  32'd0);
        checkOutput("idle imm9",   32'(bus.imm9),   32'd0);
        @(negedge clk);
        checkOutput("idle drained", 32'(bus.rsp_valid), 32'd0);

        // Backpressure: fill the buffer, then hold a second request for 3 cycles.
        bus.rsp_ready = 1'b0;
        applyStimulus(1, 2'd0, 16'h0042, 9'h0, 4'h1, 0, 2'd0, 16'h0, 9'h0, 4'h0);
        checkOutput("bp first rsp_tag", 32'(bus.rsp_tag), 32'h1);
        for (int i = 0; i < 3; i++) begin
            driveInputs(1, 2'd1, 16'h0077, 9'h0, 4'h2, 0, 2'd0, 16'h0, 9'h0, 4'h0);
            #1;
            checkOutput("bp r0_ready blocked", 32'(bus.r0_ready), 32'd0);
            @(negedge clk);
        end
        checkOutput("bp stall_cnt", 32'(bus.stall_cnt), 32'd3);
        checkOutput("bp held imm",  bus.rsp_imm,         32'h0000_0042);
        checkOutput("bp held tag",  32'(bus.rsp_tag),    32'h1);
        bus.rsp_ready = 1'b1;
        #1;
        checkOutput("bp release r0_ready", 32'(bus.r0_ready), 32'd1);
        @(negedge clk);
        checkOutput("bp new imm", bus.rsp_imm,      32'h0077_0000);
        checkOutput("bp new tag", 32'(bus.rsp_tag), 32'h2);

        // Saturation: response left waiting for 300 cycles.
        driveInputs(0, 2'd0, 16'h0, 9'h0, 4'h0, 0, 2'd0, 16'h0, 9'h0, 4'h0);
        bus.rsp_ready = 1'b0;
        repeat (300) @(negedge clk);
        checkOutput("sat stall_cnt", 32'(bus.stall_cnt), 32'h0000_00FF);
        checkOutput("sat rsp_valid", 32'(bus.rsp_valid), 32'd1);

        // Asynchronous reset while full and stalled.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("midrst stall_cnt", 32'(bus.stall_cnt), 32'd0);
        checkOutput("midrst rsp_imm",   bus.rsp_imm,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;

        // First dual request after reset goes to port 0.
        driveInputs(1, 2'd0, 16'h00C0, 9'h0, 4'hC, 1, 2'd0, 16'h00D0, 9'h0, 4'hD);
        #1;
        checkOutput("post-rst r0_ready", 32'(bus.r0_ready), 32'd1);
        checkOutput("post-rst r1_ready", 32'(bus.r1_ready), 32'd0);
        @(negedge clk);
        checkOutput("post-rst rsp_id",  32'(bus.rsp_id),  32'd0);
        checkOutput("post-rst rsp_tag", 32'(bus.rsp_tag), 32'hC);

        applyStimulus(0, 2'd0, 16'h0, 9'h0, 4'h0, 0, 2'd0, 16'h0, 9'h0, 4'h0);
        applyStimulus(0, 2'd0, 16'h0, 9'h0, 4'h0, 0, 2'd0, 16'h0, 9'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
